// File: rtl/memory_bus_pkg.sv
// Shared types and helpers for the memory bus router: FSM states, error kinds
// and the offset helper for packed per-target data buses.
package memory_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } bus_state_t;

    localparam logic ERR_PROTECT = 1'b0;
    localparam logic ERR_TIMEOUT = 1'b1;

    // LSB of element idx inside a packed bus of width-bit elements.
    function automatic int slice_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Loadable down-counter bounding how long a target may hold off ready.
// Reports expiry only while running with the count exhausted.
module bus_watchdog #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             clear,
    input  logic             run,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (run && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = run && (count == '0);

endmodule

// File: rtl/memory_bus_router.sv
// CPU bus cycle decoder driving a registered req/ready handshake to banked
// targets, with write protection, timeout watchdog and a sticky error record.
module memory_bus_router
    import memory_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 8,
    parameter int BANK_LSB   = 14,
    parameter int BANK_BITS  = 2,
    parameter int PAGE_LSB   = 16,
    parameter int EXT_TARGET = 3,
    parameter logic [2**BANK_BITS-1:0] WRITE_PROTECT = 'b0010,
    parameter int TIMEOUT    = 255
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [ADDR_WIDTH-1:0]             address,
    input  logic [DATA_WIDTH-1:0]             data_in,
    output logic [DATA_WIDTH-1:0]             data_out,
    input  logic                              bus_enable,
    input  logic                              write_enable,
    output logic                              bus_halt,
    output logic [2**BANK_BITS-1:0]           tgt_req,
    output logic                              tgt_write,
    output logic [ADDR_WIDTH-1:0]             tgt_address,
    output logic [DATA_WIDTH-1:0]             tgt_wdata,
    input  logic [2**BANK_BITS-1:0]           tgt_ready,
    input  logic [(2**BANK_BITS)*DATA_WIDTH-1:0] tgt_rdata,
    output logic                              err_flag,
    output logic [BANK_BITS-1:0]              err_target,
    output logic                              err_timeout,
    input  logic                              err_clear
);

    localparam int NT = 2**BANK_BITS;
    localparam logic [BANK_BITS-1:0] EXT_SEL = BANK_BITS'(EXT_TARGET);
    localparam logic [15:0] WD_LOAD = 16'(TIMEOUT - 1);
    localparam logic [NT-1:0] REQ_ONE = NT'(1);

    bus_state_t state_q, state_d;
    logic [BANK_BITS-1:0]  sel, sel_q;
    logic [DATA_WIDTH-1:0] rdata_sel;
    logic accept, protect_hit, access_ok, timeout_hit, wd_expired;

    // Any non-zero upper page overrides the bank field.
    assign sel = (|address[ADDR_WIDTH-1:PAGE_LSB]) ? EXT_SEL : address[BANK_LSB +: BANK_BITS];
    assign rdata_sel = tgt_rdata[slice_lsb(int'(sel_q), DATA_WIDTH) +: DATA_WIDTH];
    assign bus_halt = (state_q == ST_IDLE && bus_enable) || (state_q == ST_ACCESS);

    bus_watchdog #(.CNT_W(16)) u_watchdog (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .load_value (WD_LOAD),
        .clear      (state_q == ST_DONE),
        .run        (state_q == ST_ACCESS),
        .expired    (wd_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        protect_hit = 1'b0;
        access_ok   = 1'b0;
        timeout_hit = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus_enable) begin
                    accept = 1'b1;
                    if (write_enable && WRITE_PROTECT[sel]) begin
                        protect_hit = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                // Ready wins over an expiry in the same cycle.
                if (tgt_ready[sel_q]) begin
                    access_ok = 1'b1;
                    state_d   = ST_DONE;
                end else if (wd_expired) begin
                    timeout_hit = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q       <= '0;
            tgt_req     <= '0;
            tgt_write   <= 1'b0;
            tgt_address <= '0;
            tgt_wdata   <= '0;
            data_out    <= '0;
        end else begin
            if (accept) begin
                sel_q       <= sel;
                tgt_write   <= write_enable;
                tgt_address <= address;
                tgt_wdata   <= data_in;
                if (!protect_hit) tgt_req <= REQ_ONE << sel;
            end
            if (access_ok || timeout_hit) tgt_req <= '0;
            if (access_ok && !tgt_write) data_out <= rdata_sel;
            if (timeout_hit) data_out <= '1;
        end
    end

    // First error sticks until cleared; clear beats a same-cycle error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_flag    <= 1'b0;
            err_target  <= '0;
            err_timeout <= 1'b0;
        end else if (err_clear) begin
            err_flag    <= 1'b0;
            err_target  <= '0;
            err_timeout <= 1'b0;
        end else if (!err_flag && (protect_hit || timeout_hit)) begin
            err_flag    <= 1'b1;
            err_target  <= protect_hit ? sel : sel_q;
            err_timeout <= timeout_hit ? ERR_TIMEOUT : ERR_PROTECT;
        end
    end

endmodule

// File: tb/tb_memory_bus_router.sv
// Randomised scoreboard bench for memory_bus_router against a transaction-level
// model of decode, protection, timeout, halt length and the sticky error record.
module tb_memory_bus_router;

    localparam int TO = 8;
    localparam logic [3:0] WP = 4'b0010;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] address = '0;
    logic [7:0]  data_in = '0;
    logic [7:0]  data_out;
    logic        bus_enable = 1'b0;
    logic        write_enable = 1'b0;
    logic        bus_halt;
    logic [3:0]  tgt_req;
    logic        tgt_write;
    logic [23:0] tgt_address;
    logic [7:0]  tgt_wdata;
    logic [3:0]  tgt_ready = '0;
    logic [31:0] tgt_rdata = '0;
    logic        err_flag;
    logic [1:0]  err_target;
    logic        err_timeout;
    logic        err_clear = 1'b0;

    memory_bus_router #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .data_in      (data_in),
        .data_out     (data_out),
        .bus_enable   (bus_enable),
        .write_enable (write_enable),
        .bus_halt     (bus_halt),
        .tgt_req      (tgt_req),
        .tgt_write    (tgt_write),
        .tgt_address  (tgt_address),
        .tgt_wdata    (tgt_wdata),
        .tgt_ready    (tgt_ready),
        .tgt_rdata    (tgt_rdata),
        .err_flag     (err_flag),
        .err_target   (err_target),
        .err_timeout  (err_timeout),
        .err_clear    (err_clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  dout;
        int          halt;
        int          reqc;
        logic [3:0]  reqm;
        logic        ef;
        logic [1:0]  et;
        logic        eto;
        logic [23:0] addr;
        logic        we;
        logic [7:0]  wd;
    } exp_t;

    exp_t sb[$];
    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] m_dout = '0;
    logic       m_ef = 1'b0;
    logic [1:0] m_et = '0;
    logic       m_eto = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_sel(input logic [23:0] a);
        if ((a >> 16) != 0) return 3;
        return int'((a >> 14) % 4);
    endfunction

    // Drives one CPU cycle from an IDLE slot (posedge+1) and leaves at the next IDLE slot.
    task automatic run_txn(input logic [23:0] a, input logic we, input logic [7:0] wd,
                           input int delay, input logic [7:0] rd, input logic clr);
        int s;
        int k;
        bit prot;
        bit tout;
        logic [3:0] oh;
        exp_t e;
        s    = model_sel(a);
        oh   = 4'(1 << s);
        prot = we && WP[s];
        tout = !prot && (delay >= TO);
        if (clr) begin
            m_ef = 1'b0; m_et = '0; m_eto = 1'b0;
        end
        if (prot) begin
            if (!clr && !m_ef) begin
                m_ef = 1'b1; m_et = 2'(s); m_eto = 1'b0;
            end
            e.halt = 1; e.reqc = 0; e.reqm = '0;
        end else if (tout) begin
            m_dout = 8'hFF;
            if (!m_ef) begin
                m_ef = 1'b1; m_et = 2'(s); m_eto = 1'b1;
            end
            e.halt = 1 + TO; e.reqc = TO; e.reqm = oh;
        end else begin
            if (!we) m_dout = rd;
            e.halt = 2 + delay; e.reqc = delay + 1; e.reqm = oh;
        end
        e.dout = m_dout; e.ef = m_ef; e.et = m_et; e.eto = m_eto;
        e.addr = a; e.we = we; e.wd = wd;
        sb.push_back(e);

        address = a; write_enable = we; data_in = wd; bus_enable = 1'b1; err_clear = clr;
        tgt_rdata = $urandom; tgt_rdata[s*8 +: 8] = rd;
        tgt_ready = 4'($urandom) & ~oh;
        @(posedge clk); #1;
        bus_enable = 1'b0; err_clear = 1'b0;
        address = 24'($urandom); data_in = 8'($urandom);
        k = 1;
        while (bus_halt && k < TO + 6) begin
            tgt_rdata = $urandom; tgt_rdata[s*8 +: 8] = rd;
            tgt_ready = 4'($urandom) & ~oh;
            if (!tout && !prot && (k - 1 == delay)) tgt_ready = tgt_ready | oh;
            @(posedge clk); #1;
            k++;
        end
        chk("done_reached", 32'(bus_halt), 32'(0));
        // An enable seen during DONE must not start a cycle.
        tgt_ready = '0; bus_enable = 1'($urandom); write_enable = 1'($urandom);
        @(posedge clk); #1;
        bus_enable = 1'b0;
    endtask

    // Monitor: counts halt/req cycles and checks each completion (halt falling edge).
    initial begin
        int hcnt;
        int rcnt;
        logic [3:0] ror;
        logic prev;
        exp_t e;
        hcnt = 0; rcnt = 0; ror = '0; prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hcnt = 0; rcnt = 0; ror = '0; prev = 1'b0;
            end else begin
                if (bus_halt) begin
                    hcnt++;
                    if (tgt_req != '0) begin
                        rcnt++;
                        ror = ror | tgt_req;
                    end
                end
                if (prev && !bus_halt) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 32'(sb.size()), 32'(1));
                    end else begin
                        e = sb.pop_front();
                        chk("data_out", 32'(data_out), 32'(e.dout));
                        chk("halt_cycles", 32'(hcnt), 32'(e.halt));
                        chk("req_cycles", 32'(rcnt), 32'(e.reqc));
                        chk("req_mask", 32'(ror), 32'(e.reqm));
                        chk("err_flag", 32'(err_flag), 32'(e.ef));
                        chk("err_target", 32'(err_target), 32'(e.et));
                        chk("err_timeout", 32'(err_timeout), 32'(e.eto));
                        chk("tgt_address", 32'(tgt_address), 32'(e.addr));
                        chk("tgt_write", 32'(tgt_write), 32'(e.we));
                        chk("tgt_wdata", 32'(tgt_wdata), 32'(e.wd));
                        chk("req_dropped", 32'(tgt_req), 32'(0));
                    end
                    hcnt = 0; rcnt = 0; ror = '0;
                end
                prev = bus_halt;
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data_out"}, 32'(data_out), 32'(0));
        chk({tag, "_tgt_req"}, 32'(tgt_req), 32'(0));
        chk({tag, "_bus_halt"}, 32'(bus_halt), 32'(0));
        chk({tag, "_tgt_write"}, 32'(tgt_write), 32'(0));
        chk({tag, "_tgt_address"}, 32'(tgt_address), 32'(0));
        chk({tag, "_tgt_wdata"}, 32'(tgt_wdata), 32'(0));
        chk({tag, "_err_flag"}, 32'(err_flag), 32'(0));
        chk({tag, "_err_target"}, 32'(err_target), 32'(0));
        chk({tag, "_err_timeout"}, 32'(err_timeout), 32'(0));
    endtask

    initial begin
        logic [23:0] a;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        reset = 1'b0;
        @(posedge clk); #1;

        run_txn(24'h008010, 1'b0, 8'h00, 2, 8'h5A, 1'b0);   // bank 2, 3 req cycles
        run_txn(24'h01C000, 1'b0, 8'h00, 0, 8'hC3, 1'b0);   // page 1 -> target 3
        run_txn(24'h010000, 1'b0, 8'h00, 1, 8'h17, 1'b0);   // page 1, bank 0 -> target 3
        run_txn(24'h004000, 1'b1, 8'h33, 0, 8'h00, 1'b0);   // protected write
        run_txn(24'h000000, 1'b0, 8'h00, 99, 8'h00, 1'b1);  // clear, then timeout on target 0
        run_txn(24'h008000, 1'b0, 8'h00, 99, 8'h00, 1'b0);  // second timeout is dropped
        run_txn(24'h004123, 1'b1, 8'h44, 0, 8'h00, 1'b1);   // clear beats protect error
        run_txn(24'h000040, 1'b1, 8'h99, 3, 8'hAB, 1'b0);   // write leaves data_out
        run_txn(24'h00C001, 1'b0, 8'h00, TO - 1, 8'h6E, 1'b0); // ready on last allowed cycle

        // Reset during the second ACCESS cycle.
        address = 24'h008000; write_enable = 1'b0; bus_enable = 1'b1;
        @(posedge clk); #1;
        bus_enable = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        m_dout = '0; m_ef = 1'b0; m_et = '0; m_eto = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_txn(24'h008020, 1'b0, 8'h00, 1, 8'hD2, 1'b0);

        for (int i = 0; i < 150; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'($urandom & 32'h0000FFFF);
            run_txn(a, ($urandom_range(0, 2) == 0), 8'($urandom), $urandom_range(0, 10),
                    8'($urandom), ($urandom_range(0, 7) == 0));
        end

        repeat (3) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_watchdog: simulation still running at t=%0t", $time);
        $fatal(1, "bench did not complete");
    end

endmodule
